// File: rtl/xnor_diff_decoder_if.sv
// rtl/xnor_diff_decoder_if.sv - serial line input and decoded word output bundle
interface xnor_diff_decoder_if #(
  parameter int WIDTH = 8
);
  logic             in_sync;
  logic             in_bit;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             parity_err;

  modport master (
    output in_sync, in_bit, in_valid, out_ready,
    input  in_ready, out_data, out_valid, parity_err
  );

  modport slave (
    input  in_sync, in_bit, in_valid, out_ready,
    output in_ready, out_data, out_valid, parity_err
  );
endinterface

// File: rtl/xnor_diff_decoder.sv
// rtl/xnor_diff_decoder.sv - XNOR differential line decoder, LSB-first deserializer
// Optional trailing parity bit per frame with XNOR_DEC_PARITY_EN.
module xnor_diff_decoder #(
  parameter int WIDTH      = 8,
  parameter bit INIT_LEVEL = 1'b1
) (
  input logic                clk,
  input logic                reset,
  xnor_diff_decoder_if.slave bus
);
`ifdef XNOR_DEC_PARITY_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif
  localparam int CW = $clog2(LAST + 1);
  localparam logic [CW-1:0] LAST_C = CW'(LAST);

  typedef enum logic [1:0] {IDLE, SHIFT, STALL} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             prev_q, prev_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             parity_err_q, parity_err_d;

  logic             stalled;
  logic             accept;
  logic             dec_bit;
  logic             last_bit;
  logic             perr;
  logic [WIDTH-1:0] word_nxt;

  // STALL is only ever entered with count at the final slot and a word pending
  assign stalled  = (state_q == STALL) && !bus.out_ready;
  assign accept   = bus.in_valid && !stalled && !bus.in_sync;
  assign dec_bit  = ~(bus.in_bit ^ prev_q);
  assign last_bit = (count_q == LAST_C);

`ifdef XNOR_DEC_PARITY_EN
  assign perr = (^shift_q) ^ dec_bit;
`else
  assign perr = 1'b0;
`endif

  always_comb begin
    word_nxt = shift_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (count_q == CW'(i)) word_nxt[i] = dec_bit;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    prev_d       = prev_q;
    shift_d      = shift_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    parity_err_d = parity_err_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d  = 1'b0;
      parity_err_d = 1'b0;
    end

    if (bus.in_sync) begin
      prev_d  = INIT_LEVEL;
      count_d = '0;
      shift_d = '0;
    end else if (accept) begin
      prev_d = bus.in_bit;
      if (last_bit) begin
        count_d      = '0;
        shift_d      = '0;
        out_data_d   = word_nxt;
        out_valid_d  = 1'b1;
        parity_err_d = perr;
      end else begin
        count_d = count_q + CW'(1);
        shift_d = word_nxt;
      end
    end

    if (count_d == '0)                        state_d = IDLE;
    else if (count_d == LAST_C && out_valid_d) state_d = STALL;
    else                                      state_d = SHIFT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      prev_q       <= INIT_LEVEL;
      shift_q      <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      prev_q       <= prev_d;
      shift_q      <= shift_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign bus.in_ready   = !stalled;
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.parity_err = parity_err_q;
endmodule

// File: doc/xnor_diff_decoder.md
Name: xnor_diff_decoder

Overview:
Serial differential (XNOR-coded) line decoder. It is the receive end of the team's XNOR differential encoder, where an encoded bit equals the data bit XNOR the previous encoded bit. Each decoded bit is recovered as the received bit XNOR the previous received bit. Decoded bits are deserialized LSB-first into WIDTH-bit words and handed to downstream logic over a valid/ready handshake.

Parameters:
WIDTH, 8, decoded word width in bits; legal range 2..32.
INIT_LEVEL, 1, reference line level loaded into the previous-bit register on reset and on in_sync.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
in_sync  input  1  one-cycle frame-start pulse; re-arms the decoder.
in_bit  input  1  encoded serial bit.
in_valid  input  1  in_bit is valid this cycle.
in_ready  output  1  decoder accepts in_bit this cycle.
out_data  output  WIDTH  decoded word.
out_valid  output  1  out_data holds a complete word.
out_ready  input  1  downstream accepts out_data.
parity_err  output  1  parity flag for the current out_data (see Optional Feature).

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset. Reset is sampled only on the rising edge of clk.
- Reset values:
  - out_data = 0, out_valid = 0, parity_err = 0.
  - prev = INIT_LEVEL, bit count = 0, state = IDLE.
  - in_ready = 1 in the cycle after reset is released.
- Bit accept: a bit is accepted when in_valid && in_ready && !in_sync. On accept:
  - d = ~(in_bit ^ prev); prev <= in_bit.
  - shift[count] <= d; count <= count + 1.
- States:
  - IDLE: count = 0. An accepted bit moves to SHIFT. With WIDTH = 2 this also holds; the final-bit rule below covers the completing bit.
  - SHIFT: 0 < count < WIDTH-1. Accepted bits increment count. Reaching count == WIDTH-1 stays in SHIFT, with the final-bit rule armed.
  - Final bit (count == WIDTH-1 accepted): the completed word, including the final d, loads into out_data; out_valid = 1 on the next edge (latency 1 cycle after final-bit acceptance). count returns to 0 and the state returns to IDLE.
  - STALL: count == WIDTH-1, out_valid = 1, out_ready = 0. in_ready = 0. Exits to SHIFT-final behaviour when out_ready rises.
- in_ready = !(count == WIDTH-1 && out_valid && !out_ready). Combinational, no other dependencies.
- Output handshake:
  - out_valid && out_ready clears out_valid next edge, unless a new word completes on the same edge. In that case out_data reloads and out_valid stays 1 (back-to-back, no bubble).
  - out_data is stable while out_valid && !out_ready.
- in_sync:
  - Next edge: prev <= INIT_LEVEL, count <= 0, partial word discarded, state IDLE.
  - A pending out_data/out_valid is NOT disturbed.
  - in_sync with in_valid in the same cycle: sync wins and the bit is dropped.
- Reset mid-word or mid-STALL: all state returns to reset values on that edge and the held word is lost.
- in_valid = 0 cycles: no state change; prev holds across gaps.

Optional Feature:
Macro XNOR_DEC_PARITY_EN.
- Defined:
  - Each frame is WIDTH data bits followed by one decoded parity bit, also XNOR-decoded and chained through prev.
  - count runs 0..WIDTH, and the final-bit rule applies at count == WIDTH.
  - parity_err loads with out_data: 1 if the XOR of the WIDTH data bits and the parity bit is 1 (even parity expected); cleared with out_valid.
  - in_ready and STALL use count == WIDTH.
- Undefined: no parity bit; parity_err is tied to 0.

Test Plan:
1. Reset, then in_valid=1 with encoded stream 1,0,0,1,0,0,1,1 (first bit first), out_ready=1 -> out_data=0xA5, out_valid=1 exactly one cycle after the 8th bit, and for one cycle only.
2. Eight consecutive 1s after reset -> 0xFF. Then 1,0,1,0,1,0,1,0 -> 0x01 (prev carried from the prior word, value 1).
3. out_ready=0, send 15 bits of a second word after 0xA5 -> out_data holds 0xA5 and in_ready=0 at count 7. Raise out_ready -> 8th bit accepted that cycle, next out_data is the new word, with no gap in out_valid.
4. After 4 bits of a word, pulse in_sync with in_valid=1 -> that bit dropped, count=0, prev=1. Then 1,0,0,1,0,0,1,1 -> 0xA5.
5. Assert reset while in STALL with out_valid=1 -> next edge: out_valid=0, out_data=0, in_ready=1.
6. With XNOR_DEC_PARITY_EN: send 0xA5 encoded plus parity encoded from d=0 -> parity_err=0. Repeat with parity d=1 -> parity_err=1 alongside out_data=0xA5.
